// File: rtl/prim_stream_unpack_pkg.sv
// Shared stream helpers: beat-count arithmetic and the unpacker state encoding.
package prim_stream_unpack_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } unpack_state_e;

   // Number of narrow beats carried by one wide word.
   function automatic int unsigned ratio(input int unsigned in_w, input int unsigned out_w);
      return in_w / out_w;
   endfunction

   // Width of a counter able to hold 0..r inclusive.
   function automatic int unsigned cnt_width(input int unsigned r);
      return $clog2(r + 1);
   endfunction

endpackage

// File: rtl/prim_stream_unpack_if.sv
// Wide-in / narrow-out valid/ready stream bundle used by prim_stream_unpack.
interface prim_stream_unpack_if
   import prim_stream_unpack_pkg::*;
#(
   parameter int unsigned InW  = 32,
   parameter int unsigned OutW = 8
) ();

   localparam int unsigned CntW = cnt_width(ratio(InW, OutW));

   logic            in_valid_i;
   logic            in_ready_o;
   logic [InW-1:0]  in_data_i;
   logic [CntW-1:0] in_len_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [OutW-1:0] out_data_o;
   logic            out_last_o;

   // Unpacker side: consumes words, produces beats.
   modport slave (
      input  in_valid_i, in_data_i, in_len_i, out_ready_i,
      output in_ready_o, out_valid_o, out_data_o, out_last_o
   );

   // Environment side: produces words, consumes beats.
   modport master (
      output in_valid_i, in_data_i, in_len_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_data_o, out_last_o
   );

endinterface

// File: rtl/prim_stream_unpack.sv
// Splits one InW-bit word into up to InW/OutW OutW-bit beats on a valid/ready stream.
module prim_stream_unpack
   import prim_stream_unpack_pkg::*;
#(
   parameter int unsigned InW      = 32,
   parameter int unsigned OutW     = 8,
   parameter bit          MsbFirst = 1'b0,
   parameter bit          ZeroIdle = 1'b1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clr_i,
   prim_stream_unpack_if.slave bus,
   output logic                busy_o,
   output logic                err_o
);

   localparam int unsigned Ratio = ratio(InW, OutW);
   localparam int unsigned CntW  = cnt_width(Ratio);
   localparam logic [CntW-1:0] LenMax = CntW'(Ratio);

   if (((InW % OutW) != 0) || (Ratio < 2)) begin : g_bad_params
      $error("prim_stream_unpack: InW must be a multiple of OutW with InW/OutW >= 2");
   end

   unpack_state_e   r_state, w_state_nxt;
   logic [InW-1:0]  r_data;
   logic [CntW-1:0] r_idx, r_len, w_sel;
   logic            r_err;
   logic            w_valid, w_last, w_in_ready, w_accept, w_xfer, w_len_bad;
   logic [OutW-1:0] w_beat;

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Held word, beat index, beat count and sticky length error.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_data <= '0;
         r_idx  <= '0;
         r_len  <= '0;
         r_err  <= 1'b0;
      end else if (clr_i) begin
         r_idx  <= '0;
         r_err  <= 1'b0;
      end else if (w_accept) begin
         r_data <= bus.in_data_i;
         r_len  <= w_len_bad ? LenMax : bus.in_len_i;
         r_idx  <= '0;
         r_err  <= r_err | w_len_bad;
      end else if (w_xfer && !w_last) begin
         r_idx  <= r_idx + CntW'(1);
      end
   end

   // Next state: a last-beat transfer reloads directly when a new word is accepted.
   always_comb begin
      w_state_nxt = r_state;
      if (clr_i) begin
         w_state_nxt = ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_EMIT;
            ST_EMIT: if (w_xfer && w_last) w_state_nxt = w_accept ? ST_EMIT : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Outputs, handshake and beat mux; everything driven from registers except in_ready's out_ready term.
   always_comb begin
      w_valid    = (r_state == ST_EMIT);
      w_last     = w_valid && (r_idx == (r_len - CntW'(1)));
      w_in_ready = !clr_i && (!w_valid || (bus.out_ready_i && w_last));
      w_accept   = bus.in_valid_i && w_in_ready;
      w_xfer     = w_valid && bus.out_ready_i;
      w_len_bad  = (bus.in_len_i == '0) || (bus.in_len_i > LenMax);
      w_sel      = MsbFirst ? ((LenMax - CntW'(1)) - r_idx) : r_idx;
      w_beat     = r_data[w_sel*OutW +: OutW];

      bus.in_ready_o  = w_in_ready;
      bus.out_valid_o = w_valid;
      bus.out_last_o  = w_last;
      bus.out_data_o  = (ZeroIdle && !w_valid) ? '0 : w_beat;
      busy_o          = w_valid;
      err_o           = r_err;
   end

endmodule

// File: tb/tb_prim_stream_unpack.sv
// Directed bench for prim_stream_unpack: LSB-first/ZeroIdle instance plus an MSB-first/stale-idle instance.
module tb_prim_stream_unpack;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   logic clr0   = 1'b0;
   logic clr1   = 1'b0;
   logic busy0, err0, busy1, err1;

   int n_checks = 0;
   int n_errors = 0;

   prim_stream_unpack_if #(.InW(32), .OutW(8)) bus0 ();
   prim_stream_unpack_if #(.InW(32), .OutW(8)) bus1 ();

   prim_stream_unpack #(.InW(32), .OutW(8), .MsbFirst(1'b0), .ZeroIdle(1'b1)) dut0 (
      .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr0), .bus(bus0), .busy_o(busy0), .err_o(err0)
   );

   prim_stream_unpack #(.InW(32), .OutW(8), .MsbFirst(1'b1), .ZeroIdle(1'b0)) dut1 (
      .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr1), .bus(bus1), .busy_o(busy1), .err_o(err1)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; callers drive, then wait #2 before checking.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic beat0(input string tag, input logic v, input logic [7:0] d, input logic l);
      #2;
      chk({tag, " valid"}, 32'(bus0.out_valid_o), 32'(v));
      chk({tag, " data"},  32'(bus0.out_data_o),  32'(d));
      chk({tag, " last"},  32'(bus0.out_last_o),  32'(l));
   endtask

   initial begin
      bus0.in_valid_i = 1'b0; bus0.in_data_i = '0; bus0.in_len_i = '0; bus0.out_ready_i = 1'b1;
      bus1.in_valid_i = 1'b0; bus1.in_data_i = '0; bus1.in_len_i = '0; bus1.out_ready_i = 1'b1;

      // Reset values.
      #3;
      beat0("rst", 1'b0, 8'h00, 1'b0);
      chk("rst busy", 32'(busy0), 32'd0);
      chk("rst err", 32'(err0), 32'd0);
      chk("rst in_ready", 32'(bus0.in_ready_o), 32'd1);
      chk("rst stale data msb", 32'(bus1.out_data_o), 32'h0);
      #10 rst_ni = 1'b1;

      // 1: single word, LSB first.
      tick();
      bus0.in_valid_i = 1'b1; bus0.in_data_i = 32'hDDCCBBAA; bus0.in_len_i = 3'd4;
      #2 chk("t1 in_ready idle", 32'(bus0.in_ready_o), 32'd1);
      chk("t1 no comb path", 32'(bus0.out_valid_o), 32'd0);
      tick(); bus0.in_valid_i = 1'b0;
      beat0("t1 b0", 1'b1, 8'hAA, 1'b0);
      chk("t1 busy", 32'(busy0), 32'd1);
      tick(); beat0("t1 b1", 1'b1, 8'hBB, 1'b0);
      tick(); beat0("t1 b2", 1'b1, 8'hCC, 1'b0);
      tick(); beat0("t1 b3", 1'b1, 8'hDD, 1'b1);
      tick(); beat0("t1 idle", 1'b0, 8'h00, 1'b0);

      // 2: back-to-back words, no bubble.
      tick();
      bus0.in_valid_i = 1'b1; bus0.in_data_i = 32'h04030201; bus0.in_len_i = 3'd4;
      tick(); bus0.in_data_i = 32'h08070605;
      beat0("t2 b0", 1'b1, 8'h01, 1'b0);
      chk("t2 in_ready mid", 32'(bus0.in_ready_o), 32'd0);
      tick(); beat0("t2 b1", 1'b1, 8'h02, 1'b0);
      tick(); beat0("t2 b2", 1'b1, 8'h03, 1'b0);
      tick(); beat0("t2 b3", 1'b1, 8'h04, 1'b1);
      chk("t2 in_ready last", 32'(bus0.in_ready_o), 32'd1);
      tick(); bus0.in_valid_i = 1'b0;
      beat0("t2 b4", 1'b1, 8'h05, 1'b0);
      tick(); beat0("t2 b5", 1'b1, 8'h06, 1'b0);
      tick(); beat0("t2 b6", 1'b1, 8'h07, 1'b0);
      tick(); beat0("t2 b7", 1'b1, 8'h08, 1'b1);
      tick(); beat0("t2 idle", 1'b0, 8'h00, 1'b0);

      // 3: len=2 with a three-cycle sink stall on beat 0.
      tick();
      bus0.in_valid_i = 1'b1; bus0.in_data_i = 32'h44332211; bus0.in_len_i = 3'd2;
      bus0.out_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); bus0.in_valid_i = 1'b0;
         beat0("t3 stall", 1'b1, 8'h11, 1'b0);
         chk("t3 in_ready stall", 32'(bus0.in_ready_o), 32'd0);
      end
      tick(); bus0.out_ready_i = 1'b1;
      beat0("t3 b0", 1'b1, 8'h11, 1'b0);
      tick(); beat0("t3 b1", 1'b1, 8'h22, 1'b1);
      tick(); beat0("t3 idle", 1'b0, 8'h00, 1'b0);

      // 4: MSB-first instance, then stale data while idle.
      tick();
      bus1.in_valid_i = 1'b1; bus1.in_data_i = 32'h01020304; bus1.in_len_i = 3'd4;
      tick(); bus1.in_valid_i = 1'b0;
      #2 chk("t4 b0", 32'(bus1.out_data_o), 32'h01);
      tick(); #2 chk("t4 b1", 32'(bus1.out_data_o), 32'h02);
      tick(); #2 chk("t4 b2", 32'(bus1.out_data_o), 32'h03);
      tick(); #2 chk("t4 b3", 32'(bus1.out_data_o), 32'h04);
      chk("t4 last", 32'(bus1.out_last_o), 32'd1);
      tick(); #2 chk("t4 idle valid", 32'(bus1.out_valid_o), 32'd0);
      chk("t4 idle stale", 32'(bus1.out_data_o), 32'h04);

      // 5: len=0 emits a full word and sets err; len=5 then clr mid-word.
      tick();
      bus0.in_valid_i = 1'b1; bus0.in_data_i = 32'hDDCCBBAA; bus0.in_len_i = 3'd0;
      tick(); bus0.in_valid_i = 1'b0;
      beat0("t5 b0", 1'b1, 8'hAA, 1'b0);
      chk("t5 err set", 32'(err0), 32'd1);
      tick(); beat0("t5 b1", 1'b1, 8'hBB, 1'b0);
      tick(); beat0("t5 b2", 1'b1, 8'hCC, 1'b0);
      tick(); beat0("t5 b3", 1'b1, 8'hDD, 1'b1);
      tick(); beat0("t5 idle", 1'b0, 8'h00, 1'b0);
      chk("t5 err held", 32'(err0), 32'd1);
      tick();
      bus0.in_valid_i = 1'b1; bus0.in_data_i = 32'h87654321; bus0.in_len_i = 3'd5;
      tick(); bus0.in_valid_i = 1'b0;
      beat0("t5 w2 b0", 1'b1, 8'h21, 1'b0);
      tick(); beat0("t5 w2 b1", 1'b1, 8'h43, 1'b0);
      clr0 = 1'b1; bus0.in_valid_i = 1'b1; bus0.in_len_i = 3'd4;
      #2 chk("t5 clr in_ready", 32'(bus0.in_ready_o), 32'd0);
      tick(); clr0 = 1'b0; bus0.in_valid_i = 1'b0;
      beat0("t5 after clr", 1'b0, 8'h00, 1'b0);
      chk("t5 err cleared", 32'(err0), 32'd0);
      chk("t5 busy cleared", 32'(busy0), 32'd0);

      // 6: reset mid-word.
      tick();
      bus0.in_valid_i = 1'b1; bus0.in_data_i = 32'hDDCCBBAA; bus0.in_len_i = 3'd4;
      tick(); bus0.in_valid_i = 1'b0;
      beat0("t6 b0", 1'b1, 8'hAA, 1'b0);
      tick(); beat0("t6 b1", 1'b1, 8'hBB, 1'b0);
      rst_ni = 1'b0;
      beat0("t6 rst async", 1'b0, 8'h00, 1'b0);
      chk("t6 rst in_ready", 32'(bus0.in_ready_o), 32'd1);
      tick(); tick();
      rst_ni = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); beat0("t6 no beats", 1'b0, 8'h00, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
